// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - Multi-cycle integer ALU with the RV32M multiply/divide group
//
// Base ops finish in one registered cycle. MUL*/DIV*/REM* run WIDTH iterations
// of shift-add or restoring divide on operand magnitudes, then a fix-up cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous abort of in-flight op and pending result
//   in_valid/in_ready   operation handshake (in_a, in_b, control)
//   control             [4]=0 base op in [3:0]; [4]=1 M op, funct3 in [2:0]
//   out_valid/out_ready result handshake (alu_out, zero)
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_HOLD} state_e;

  localparam int             CW       = SHW + 1;
  localparam logic [CW-1:0]  ITERS    = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  // Multiply: {partial product hi, remaining multiplier}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opb_q;
  logic [2:0]           f3_q;
  logic                 a_neg_q;
  logic                 b_neg_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     res_q;
  logic                 zero_q;

  logic                 accept;

  assign in_ready  = !flush && ((state_q == S_IDLE) || (state_q == S_HOLD && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign alu_out   = res_q;
  assign zero      = zero_q;

  // Base ALU
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] base_res;
  assign shamt = in_b[SHW-1:0];

  always_comb begin
    base_res = in_a;
    case (control[3:0])
      4'b0000: base_res = in_a + in_b;
      4'b1000: base_res = in_a - in_b;
      4'b0001: base_res = in_a << shamt;
      4'b0101: base_res = in_a >> shamt;
      4'b1101: base_res = $signed(in_a) >>> shamt;
      4'b0010: base_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      4'b0011: base_res = {{(WIDTH-1){1'b0}}, in_a < in_b};
      4'b0100: base_res = in_a ^ in_b;
      4'b0110: base_res = in_a | in_b;
      4'b0111: base_res = in_a & in_b;
      default: base_res = in_a;
    endcase
  end

  // M-op setup: operand magnitudes and the special cases that skip iteration
  logic [2:0]       f3;
  logic             is_div;
  logic             a_sgn;
  logic             b_sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             fast;
  logic [WIDTH-1:0] fast_res;
  logic [WIDTH-1:0] acc_res;

  always_comb begin
    f3       = control[2:0];
    is_div   = f3[2];
    a_sgn    = is_div ? !f3[0] : (f3 == 3'b001 || f3 == 3'b010);
    b_sgn    = is_div ? !f3[0] : (f3 == 3'b001);
    a_neg    = a_sgn && in_a[WIDTH-1];
    b_neg    = b_sgn && in_b[WIDTH-1];
    a_mag    = a_neg ? -in_a : in_a;
    b_mag    = b_neg ? -in_b : in_b;
    fast     = 1'b0;
    fast_res = '0;
    if (is_div && in_b == '0) begin
      fast     = 1'b1;
      fast_res = f3[1] ? in_a : ALL_ONES;
    end else if (is_div && !f3[0] && in_a == MIN_NEG && in_b == ALL_ONES) begin
      fast     = 1'b1;
      fast_res = f3[1] ? '0 : in_a;
    end
    acc_res = control[4] ? fast_res : base_res;
  end

  // One iteration step
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_add   = acc_q[0] ? opb_q : '0;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (f3_q[2]) begin
      // A borrow means the divisor did not fit: keep the shifted remainder.
      acc_step = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Fix-up: restore signs and select the requested half
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_res;

  always_comb begin
    prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quo_fix  = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (f3_q[2]) begin
      fix_res = f3_q[1] ? rem_fix : quo_fix;
    end else begin
      fix_res = (f3_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      f3_q        <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b1;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_ITER: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          res_q       <= fix_res;
          zero_q      <= (fix_res == '0);
          out_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        default: begin
          if (state_q == S_HOLD && out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            if (!control[4] || fast) begin
              res_q       <= acc_res;
              zero_q      <= (acc_res == '0);
              out_valid_q <= 1'b1;
              state_q     <= S_HOLD;
            end else begin
              acc_q       <= {{WIDTH{1'b0}}, a_mag};
              opb_q       <= b_mag;
              f3_q        <= f3;
              a_neg_q     <= a_neg;
              b_neg_q     <= b_neg;
              cnt_q       <= ITERS;
              out_valid_q <= 1'b0;
              state_q     <= S_ITER;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - Self-checking bench for alu_seq against an arithmetic reference
module tb_alu_seq;

  localparam int W    = 32;
  localparam int MLAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [4:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         zero;

  int n_chk  = 0;
  int n_pass = 0;
  logic rand_rdy = 1'b0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .control  (control),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out  (alu_out),
    .zero     (zero)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain 64-bit arithmetic on the operation's definition
  function automatic logic [W-1:0] model_res(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub, p;
    int sh;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    sh = int'(b[4:0]);
    p  = ua;
    if (!c[4]) begin
      case (c[3:0])
        4'h0: p = ua + ub;
        4'h8: p = ua - ub;
        4'h1: p = ua << sh;
        4'h5: p = ua >> sh;
        4'hD: p = sa >>> sh;
        4'h2: p = (sa < sb) ? 64'd1 : 64'd0;
        4'h3: p = (ua < ub) ? 64'd1 : 64'd0;
        4'h4: p = ua ^ ub;
        4'h6: p = ua | ub;
        4'h7: p = ua & ub;
        default: p = ua;
      endcase
      return p[31:0];
    end
    case (c[2:0])
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    if (!c[4]) return 1;
    if (!c[2]) return MLAT;
    if (b == 0) return 1;
    if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return MLAT;
  endfunction

  // Compare process: tracks at most one outstanding op and checks every cycle
  logic         have = 1'b0;
  logic [W-1:0] e_res, acc_res;
  int           e_lat, acc_lat, acc_cyc, cyc = 0;
  logic         exp_valid, exp_rdy, do_acc, do_pop, flush_s;

  initial begin
    do_acc  = 1'b0;
    do_pop  = 1'b0;
    flush_s = 1'b0;
    e_res   = '0;
    e_lat   = 1;
    acc_cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n || flush_s) begin
        have = 1'b0;
      end else begin
        if (do_pop) have = 1'b0;
        if (do_acc) begin
          have    = 1'b1;
          e_res   = acc_res;
          e_lat   = acc_lat;
          acc_cyc = cyc;
        end
      end
      @(negedge clk);
      exp_valid = have && (cyc - acc_cyc + 1 >= e_lat);
      exp_rdy   = !flush && (!have || (exp_valid && out_ready));
      do_pop    = 1'b0;
      do_acc    = 1'b0;
      flush_s   = flush;
      if (rst_n) begin
        check("out_valid", out_valid, exp_valid);
        check("in_ready", in_ready, exp_rdy);
        if (exp_valid) begin
          check("alu_out", alu_out, e_res);
          check("zero", zero, e_res == 0);
        end
        do_pop = exp_valid && out_ready;
        if (in_valid && exp_rdy) begin
          do_acc  = 1'b1;
          acc_res = model_res(control, in_a, in_b);
          acc_lat = model_lat(control, in_a, in_b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n        = 0;
    control  = c;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        n_chk++;
        $display("FAIL accept_timeout: in_ready %0b after %0d cycles, required 1", in_ready, n);
        break;
      end
      step();
    end
    step();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    control  = 5'($urandom);
  endtask

  task automatic wait_out(input int lim);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > lim) begin
        n_chk++;
        $display("FAIL out_timeout: out_valid %0b after %0d cycles, required 1", out_valid, n);
        break;
      end
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [4:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
  } vec_t;

  vec_t dir [12];

  initial begin
    dir = '{
      '{5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000},
      '{5'b01000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000},
      '{5'b01101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
      '{5'b00010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
      '{5'b00011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
      '{5'b10001, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF},
      '{5'b10000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1},
      '{5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
      '{5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
      '{5'b10101, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF},
      '{5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000}
    };
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    control   = '0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_out", alu_out, 0);
    check("rst_zero", zero, 1);
    step();
    rst_n = 1'b1;

    // Directed vectors back-to-back; literals pin the reference model
    foreach (dir[i]) begin
      check("model_pin", model_res(dir[i].c, dir[i].a, dir[i].b), dir[i].e);
      issue(dir[i].c, dir[i].a, dir[i].b);
    end
    repeat (MLAT + 2) step();

    // Consumer stall on a long op, then release with the next op waiting
    out_ready = 1'b0;
    issue(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(MLAT + 5);
    repeat (5) step();
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_alu_out", alu_out, 32'hFFFF_FFFE);
    step();
    out_ready = 1'b1;
    issue(5'b00000, 32'h0000_0001, 32'h0000_0002);
    repeat (3) step();

    // Flush during ITER
    issue(5'b10100, 32'd100, 32'd7);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    repeat (MLAT + 4) step();

    // Flush wins over out_ready in HOLD, and blocks a simultaneous op
    out_ready = 1'b0;
    issue(5'b00000, 32'd2, 32'd3);
    wait_out(5);
    step();
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    control   = 5'b00000;
    in_a      = 32'd9;
    in_b      = 32'd9;
    @(negedge clk);
    check("flush_blocks_accept", in_ready, 0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_drops_result", out_valid, 0);
    repeat (3) step();

    // Asynchronous reset in the middle of a divide
    issue(5'b00000, 32'd3, 32'd4);
    issue(5'b10100, 32'hFFFF_FFF9, 32'd2);
    repeat (5) step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_alu_out", alu_out, 0);
    check("arst_zero", zero, 1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Randomized traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      issue(5'($urandom), pick(), pick());
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) step();
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    repeat (MLAT + 4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at t=%0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the PegasusCore execute stage, extending the base integer ALU with the RV32M multiply/divide group.
- Base operations complete with one-cycle registered latency.
- MUL*/DIV*/REM* run on an iterative shift-add / restoring-divide datapath taking WIDTH+2 cycles.
- A valid/ready handshake on both sides lets the core stall on long operations.

## Interface
- WIDTH, 32: operand and result width; must be a power of two and at least 8.
- SHW, $clog2(WIDTH): shift-amount width, derived; do not override.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assertion, active-low.
- One clock; reset is asynchronous and active-low.
- flush  input  1  synchronous abort: drops any in-flight operation and any pending result.
- in_valid  input  1  operands and control are valid.
- in_ready  output  1  block accepts an operation this cycle.
- in_a  input  WIDTH  operand A (rs1).
- in_b  input  WIDTH  operand B (rs2 or immediate).
- control  input  5  bit4=0: base op, [3:0] encoded as below; bit4=1: M op, [2:0] = funct3.
- out_valid  output  1  alu_out and zero are valid.
- out_ready  input  1  consumer takes the result.
- alu_out  output  WIDTH  result.
- zero  output  1  1 when alu_out == 0, for every operation.

## Operation
- Base encodings:
  - 0000 ADD; 1000 SUB.
  - 0001 SLL, 0101 SRL, 1101 SRA; shift amount = in_b[SHW-1:0].
  - 0010 SLT (signed), 0011 SLTU.
  - 0100 XOR, 0110 OR, 0111 AND.
  - Any other value passes in_a through.
- M funct3: 000 MUL (low WIDTH bits), 001 MULH (s×s), 010 MULHSU (s×u), 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Operands and control are captured on acceptance (in_valid & in_ready); later input changes are ignored.
- States:
  - IDLE: accepts operations.
  - ITER: runs WIDTH iterations under a down-counter.
  - FIX: sign correction and hi/lo or quotient/remainder select.
  - HOLD: result presented.
- Base op: IDLE → HOLD at the acceptance edge.
- M op, normal case: IDLE → ITER → FIX → HOLD.
- M op, fast-path (IDLE → HOLD directly):
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = in_a.
  - Signed overflow (in_a = 1 followed by WIDTH-1 zeros, in_b = all ones): DIV = in_a; REM = 0.
- Signed multiply/divide work on magnitudes:
  - Product is negated in FIX if the operand signs differ.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Multiply keeps a 2×WIDTH product register; MULH* return bits [2W-1:W].
- HOLD → IDLE when out_ready = 1.
- in_ready = 1 in IDLE, and also in HOLD when out_ready = 1. This gives back-to-back base ops at throughput 1 per cycle.
- flush: next state is IDLE, out_valid is 0, and the counter is cleared. An operation presented in the same cycle as flush is not accepted (in_ready is forced to 0).

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, alu_out 0, zero 1, counter 0, internal registers 0.
- Base op latency: out_valid rises 1 cycle after the acceptance edge.
- M op latency: out_valid rises exactly WIDTH+2 cycles after the acceptance edge (34 at WIDTH=32).
- Fast-path latency: 1 cycle.
- alu_out and zero are registered and stay stable while out_valid & !out_ready.
- in_ready is 0 in ITER and FIX.
- Reset mid-operation: immediate return to reset values; no result is produced.
- flush and out_ready in the same cycle: flush wins and the result is discarded.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 1 with out_ready=1:
  - alu_out 0x80000000, zero 0, out_valid 1 cycle after acceptance.
  - Next: SUB 5−5 gives 0 with zero 1.
- SRA 0x80000000 by in_b=0x24 (amount 4) → 0xF8000000; SLT −1 < 1 → 1; SLTU 0xFFFFFFFF < 1 → 0.
- MULH −3 × 5 → 0xFFFFFFFF; MUL −3 × 5 → 0xFFFFFFF1; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - Each: out_valid 34 cycles after acceptance; in_ready 0 throughout ITER/FIX.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 7/0 → 0xFFFFFFFF in 1 cycle; DIV 0x80000000 / −1 → 0x80000000 in 1 cycle.
- out_ready held 0 for 5 cycles after out_valid: result stable, in_ready 0. Release: in_ready goes 1 that cycle and the next op is accepted.
- flush at ITER cycle 10 → IDLE next cycle, no out_valid; rst_n low mid-DIV → outputs return to reset values asynchronously.
